// File: rtl/sdram_rr_port_arbiter_if.sv
// Client and SDRAM-controller side bundle of the round-robin port arbiter.
// The master modport is the arbiter's view; slave is the clients + controller.
interface sdram_rr_port_arbiter_if #(
    parameter int AW   = 25,
    parameter int NCLI = 4
);
    logic [NCLI-1:0]    cli_req;
    logic [NCLI-1:0]    cli_we;
    logic [NCLI*AW-1:0] cli_addr;
    logic [2*NCLI-1:0]  cli_ds;
    logic [16*NCLI-1:0] cli_d;
    logic [NCLI-1:0]    cli_ack;
    logic [31:0]        cli_q;

    logic               mem_req;
    logic               mem_ack;
    logic               mem_we;
    logic [AW-1:0]      mem_a;
    logic [1:0]         mem_ds;
    logic [15:0]        mem_d;
    logic [31:0]        mem_q;

    modport master (
        input  cli_req, cli_we, cli_addr, cli_ds, cli_d, mem_ack, mem_q,
        output cli_ack, cli_q, mem_req, mem_we, mem_a, mem_ds, mem_d
    );

    modport slave (
        output cli_req, cli_we, cli_addr, cli_ds, cli_d, mem_ack, mem_q,
        input  cli_ack, cli_q, mem_req, mem_we, mem_a, mem_ds, mem_d
    );
endinterface

// File: rtl/sdram_rr_port_arbiter.sv
// Round-robin share of one toggle-handshake SDRAM port among four level-request clients.
// Latency: mem_req toggles 1 cycle after a sampled request; cli_ack pulses 1 cycle after mem_ack == mem_req.
// Backpressure: one transaction in flight, clients hold cli_req until cli_ack. Watchdog option: SDRAM_ARB_WATCHDOG_EN.
module sdram_rr_port_arbiter #(
    parameter int AW      = 25,
    parameter int NCLI    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    sdram_rr_port_arbiter_if.master       bus,
    output logic                          busy,
    output logic [1:0]                    grant_id,
    output logic                          timeout_err
);
    typedef enum logic [1:0] {SYNC, IDLE, WAIT, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] last;
    logic [1:0] pick;
    logic [1:0] scan_idx;
    logic       pick_vld;
    logic       ack_match;

    assign ack_match = (bus.mem_ack == bus.mem_req);

    // Scan downward so the nearest client after 'last' is the final (winning) hit.
    always_comb begin
        pick     = last;
        pick_vld = 1'b0;
        scan_idx = last;
        for (int k = NCLI; k >= 1; k--) begin
            scan_idx = last + 2'(k);
            if (bus.cli_req[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= SYNC;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:    if (ack_match) state_nxt = IDLE;
            IDLE:    if (pick_vld)  state_nxt = WAIT;
            WAIT:    if (ack_match) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.mem_a   <= '0;
            bus.mem_ds  <= 2'b00;
            bus.mem_d   <= 16'h0000;
            bus.cli_ack <= '0;
            bus.cli_q   <= 32'h0;
            busy        <= 1'b0;
            grant_id    <= 2'd3;
            last        <= 2'd3;
        end else begin
            bus.cli_ack <= '0;
            case (state)
                IDLE: if (pick_vld) begin
                    bus.mem_we  <= bus.cli_we[pick];
                    bus.mem_a   <= bus.cli_addr[int'(pick)*AW +: AW];
                    bus.mem_ds  <= bus.cli_ds[int'(pick)*2 +: 2];
                    bus.mem_d   <= bus.cli_d[int'(pick)*16 +: 16];
                    bus.mem_req <= ~bus.mem_req;
                    grant_id    <= pick;
                    busy        <= 1'b1;
                end
                WAIT: if (ack_match) begin
                    if (!bus.mem_we) bus.cli_q <= bus.mem_q;
                    bus.cli_ack[grant_id] <= 1'b1;
                    last                  <= grant_id;
                end
                // busy spans the ack pulse, then drops as DONE hands back to IDLE
                DONE: busy <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SDRAM_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    // The transaction is never abandoned; the flag only reports a stuck controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state != WAIT) begin
            wd_cnt <= '0;
        end else if (wd_cnt != CW'(TIMEOUT)) begin
            wd_cnt <= wd_cnt + CW'(1);
            if (wd_cnt == CW'(TIMEOUT - 1)) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: doc/sdram_rr_port_arbiter.md
Name: sdram_rr_port_arbiter

Overview:
Shares one toggle-handshake SDRAM controller port (bank-group port with req/ack toggle, 25-bit word address, 32-bit burst read data) between four level-request clients, e.g. sprite fetch, ADPCM-A, ADPCM-B and loader. It sits between the video/audio fetch units and the SDRAM controller. It grants round-robin, issues one transaction at a time, and returns read data with a one-cycle ack pulse per client.

Parameters:
AW, 25, word address width (client/mem address bits [AW:1])
NCLI, 4, number of clients (fixed at 4; grant index is 2 bits)
TIMEOUT, 255, watchdog limit in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock, same domain as SDRAM controller
reset  input  1  synchronous, active-high
cli_req  input  4  per-client level request; held until matching cli_ack
cli_we  input  4  per-client write enable
cli_addr  input  4*AW  per-client word address, client i at [i*AW +: AW]
cli_ds  input  8  per-client byte enables, client i at [2i +: 2]
cli_d  input  64  per-client write data, client i at [16i +: 16]
cli_ack  output  4  one-cycle completion pulse for the granted client
cli_q  output  32  read data, shared by all clients, valid with cli_ack
mem_req  output  1  toggle request to controller
mem_ack  input  1  controller toggle ack; transaction done when mem_ack == mem_req
mem_we  output  1  latched write enable
mem_a  output  AW  latched address
mem_ds  output  2  latched byte enables
mem_d  output  16  latched write data
mem_q  input  32  controller read data, valid when ack toggles
busy  output  1  high from grant until ack pulse, inclusive
grant_id  output  2  index of current or last granted client
timeout_err  output  1  sticky watchdog flag (optional feature only, else tied 0)

Behaviour:
- Reset values: mem_req=0, cli_ack=0, cli_q=0, mem_we=0, mem_a=0, mem_ds=0, mem_d=0, busy=0, grant_id=3, last-grant pointer=3 (client 0 wins first), state=SYNC.
- FSM states: SYNC, IDLE, WAIT, DONE.
- SYNC: wait until mem_ack == mem_req, then go to IDLE. This covers reset asserted mid-transaction while the controller still completes an outstanding toggle.
- IDLE: if cli_req != 0, choose the first set bit scanning from last+1 mod 4 upward.
  - Latch that client's we/addr/ds/d into the mem_* registers.
  - Toggle mem_req, set grant_id and busy, go to WAIT.
  - Request at cycle N produces a mem_req edge at N+1.
- WAIT: when mem_ack == mem_req:
  - Read: cli_q <= mem_q. Write: cli_q is unchanged.
  - Pulse cli_ack[grant_id] for exactly one cycle, set last=grant_id, go to DONE.
  - Ack pulse appears 1 cycle after the equality is first seen.
- DONE: one cycle. busy deasserts and no requests are sampled, which gives the client one cycle to drop cli_req. Then go to IDLE.
- Client inputs are sampled only in IDLE. Changes to cli_* during WAIT are ignored.
- If a client drops cli_req during WAIT, the transaction still completes and ack is still pulsed.
- A client still holding cli_req in IDLE after its ack is treated as a new request. It is granted only after other pending clients (round-robin fairness).
- Simultaneous requests from all 4 clients with last=3 are served in order 0,1,2,3.
- Worst-case wait for any client is 3 other transactions.
- mem_* outputs stay stable from grant until the next grant.
- Reset mid-operation clears all state and holds off new issues until SYNC completes.

Optional Feature:
Macro SDRAM_ARB_WATCHDOG_EN.
- Defined: a counter runs in WAIT and clears on state entry. Reaching TIMEOUT sets timeout_err, which stays set until reset. The FSM keeps waiting because the transaction is not abandoned.
- Undefined: no counter; timeout_err is constant 0.

Test Plan:
- Single read: client 2 reads addr 0x123456; model acks after 10 cycles with mem_q=0xDEADBEEF. Required: mem_req toggles 0->1 one cycle after request, cli_ack=4'b0100 for one cycle, cli_q=0xDEADBEEF, grant_id=2.
- Round-robin: all four req high at once, each held until its ack. Required: grant order 0,1,2,3; then client 0 alone again -> grant 0.
- Write: client 1 writes d=0xA55A, ds=2'b01. Required: mem_we=1, mem_d=0xA55A, mem_ds=01; cli_q keeps its prior value; ack pulses on bit 1.
- Hold-over fairness: client 0 keeps req high after ack while client 3 is requesting. Required: client 3 granted next, before client 0 again.
- Reset mid-WAIT: reset for 2 cycles while the model still owes an ack and later toggles mem_ack. Required: FSM stays in SYNC with no mem_req toggle until mem_ack == mem_req; then normal operation resumes.
- Watchdog (with SDRAM_ARB_WATCHDOG_EN, TIMEOUT=255): model never acks. Required: timeout_err rises after 255 WAIT cycles and stays high; without the macro, timeout_err stays 0.
